// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller for the microwave cook-time path: debounces the BCD encoder,
// shifts accepted digits into an M:SS buffer and hands the buffer to the timer on start.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       entry_en,
  output logic       enc_enablen,
  input  logic       enc_valid,
  input  logic [3:0] enc_d,
  input  logic       clr,
  input  logic       load_req,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [1:0] digit_cnt,
  output logic       full,
  output logic       key_strobe,
  output logic       load
);

  localparam logic [1:0]       S_IDLE     = 2'd0;
  localparam logic [1:0]       S_DEBOUNCE = 2'd1;
  localparam logic [1:0]       S_WAIT_REL = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       latched, latched_nx;
  logic             sample_ok;
  logic             capture;
  logic             load_fire;
  logic             accept;

  // Out-of-range encoder codes are treated exactly like no key.
  assign sample_ok = enc_valid && (enc_d <= 4'd9);
  assign full      = (digit_cnt == 2'd3);

  // The load cycle itself blocks a retrigger while digit_cnt is still non-zero.
  assign load_fire = load_req && (digit_cnt != 2'd0) && !load && !clr;
  assign accept    = capture && !full && !clr && !load_fire && !load;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    latched_nx = latched;
    capture    = 1'b0;
    if (!entry_en) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sample_ok) begin
            latched_nx = enc_d;
            cnt_nx     = CNT_ONE;
            state_nx   = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (sample_ok && (enc_d == latched)) begin
            if (cnt == CNT_LAST) begin
              capture  = 1'b1;
              cnt_nx   = '0;
              state_nx = S_WAIT_REL;
            end else begin
              cnt_nx = cnt + CNT_ONE;
            end
          end else begin
            cnt_nx   = '0;
            state_nx = S_IDLE;
          end
        end
        S_WAIT_REL: begin
          // Release needs a run of idle samples; any key activity restarts the run.
          if (sample_ok) begin
            cnt_nx = '0;
          end else if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = S_IDLE;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        default: begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      latched     <= 4'd0;
      enc_enablen <= 1'b1;
      key_strobe  <= 1'b0;
      load        <= 1'b0;
      sec_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      min_ones    <= 4'd0;
      digit_cnt   <= 2'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      latched     <= latched_nx;
      enc_enablen <= ~entry_en;
      key_strobe  <= accept;
      load        <= load_fire;
      // Buffer clears on clr or at the edge that ends the load cycle.
      if (clr || load) begin
        sec_ones  <= 4'd0;
        sec_tens  <= 4'd0;
        min_ones  <= 4'd0;
        digit_cnt <= 2'd0;
      end else if (accept) begin
        min_ones  <= sec_tens;
        sec_tens  <= sec_ones;
        sec_ones  <= latched;
        digit_cnt <= digit_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Randomized bench for keypad_entry_ctrl against a digit-queue reference model.
module tb_keypad_entry_ctrl;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       clearn, entry_en, enc_valid, clr, load_req;
  logic [3:0] enc_d;
  logic       enc_enablen, full, key_strobe, load;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic [1:0] digit_cnt;

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .clearn(clearn), .entry_en(entry_en), .enc_enablen(enc_enablen),
    .enc_valid(enc_valid), .enc_d(enc_d), .clr(clr), .load_req(load_req),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .digit_cnt(digit_cnt), .full(full), .key_strobe(key_strobe), .load(load)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  // Reference model: entered digits as a queue, press/release tracked as sample runs.
  int q[$];
  int run, dig, rel;
  bit armed, m_load, m_strobe, m_enb;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int digit_at(input int back);
    if (q.size() > back) return q[q.size() - 1 - back];
    return 0;
  endfunction

  task automatic model_reset;
    q.delete();
    run = 0; dig = 0; rel = 0;
    armed = 1; m_load = 0; m_strobe = 0; m_enb = 1;
  endtask

  task automatic model_step;
    bit v, fire, cap;
    v    = enc_valid && (enc_d <= 4'd9);
    fire = !clr && load_req && (q.size() != 0) && !m_load;
    cap  = 0;
    if (!entry_en) begin
      run = 0; rel = 0; armed = 1;
    end else if (armed) begin
      if (run == 0) begin
        if (v) begin run = 1; dig = int'(enc_d); end
      end else if (v && int'(enc_d) == dig) begin
        run++;
        if (run == DC) begin cap = 1; run = 0; armed = 0; rel = 0; end
      end else begin
        run = 0;
      end
    end else begin
      if (v) rel = 0;
      else begin
        rel++;
        if (rel == DC) begin rel = 0; armed = 1; end
      end
    end
    m_strobe = 0;
    if (clr || m_load) q.delete();
    else if (!fire && cap && q.size() < 3) begin
      q.push_back(dig);
      m_strobe = 1;
    end
    m_load = fire;
    m_enb  = !entry_en;
  endtask

  task automatic check_all;
    chk("sec_ones",    int'(sec_ones),    digit_at(0));
    chk("sec_tens",    int'(sec_tens),    digit_at(1));
    chk("min_ones",    int'(min_ones),    digit_at(2));
    chk("digit_cnt",   int'(digit_cnt),   q.size());
    chk("full",        int'(full),        int'(q.size() == 3));
    chk("key_strobe",  int'(key_strobe),  int'(m_strobe));
    chk("load",        int'(load),        int'(m_load));
    chk("enc_enablen", int'(enc_enablen), int'(m_enb));
  endtask

  task automatic tick;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (key_strobe) strobe_cnt++;
  endtask

  task automatic press(input int key, input int hold);
    enc_valid = 1'b1;
    enc_d     = 4'(key);
    repeat (hold) tick();
    enc_valid = 1'b0;
    repeat (DC + 1) tick();
  endtask

  task automatic clear_buf;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int  first;
    int  seg_left;
    bit  pressing;
    logic [3:0] key;

    clearn = 1'b0; entry_en = 1'b1; enc_valid = 1'b0; enc_d = 4'd0;
    clr = 1'b0; load_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_enablen", int'(enc_enablen), 1);
    chk("rst_cnt",     int'(digit_cnt),   0);
    clearn = 1'b1;

    // Reset pulse while a press is being debounced.
    enc_valid = 1'b1; enc_d = 4'd7;
    tick(); tick();
    clearn = 1'b0;
    #1;
    chk("rstmid_enablen", int'(enc_enablen), 1);
    chk("rstmid_strobe",  int'(key_strobe),  0);
    chk("rstmid_cnt",     int'(digit_cnt),   0);
    chk("rstmid_ones",    int'(sec_ones),    0);
    clearn = 1'b1;
    model_reset();
    enc_valid = 1'b0;
    strobe_cnt = 0;
    repeat (6) tick();
    chk("rstmid_no_strobe", strobe_cnt, 0);

    // Capture latency and single strobe.
    enc_valid = 1'b1; enc_d = 4'd3; first = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (key_strobe && first < 0) first = i;
    end
    enc_valid = 1'b0;
    repeat (6) tick();
    chk("strobe_latency", first, DC);
    chk("key3_ones", int'(sec_ones), 3);
    chk("key3_cnt",  int'(digit_cnt), 1);

    clear_buf();
    strobe_cnt = 0;
    press(6, 20);
    chk("hold_once", strobe_cnt, 1);

    // Bounce never reaches the required run.
    clear_buf();
    strobe_cnt = 0;
    enc_valid = 1'b1; enc_d = 4'd5; repeat (2) tick();
    enc_valid = 1'b0; tick();
    enc_valid = 1'b1; repeat (2) tick();
    enc_valid = 1'b0; repeat (6) tick();
    chk("bounce_strobe", strobe_cnt, 0);
    chk("bounce_cnt", int'(digit_cnt), 0);

    clear_buf();
    press(1, 6); press(2, 6); press(3, 6);
    strobe_cnt = 0;
    press(4, 6);
    chk("full_min",    int'(min_ones), 1);
    chk("full_tens",   int'(sec_tens), 2);
    chk("full_ones",   int'(sec_ones), 3);
    chk("full_flag",   int'(full),     1);
    chk("full_strobe", strobe_cnt,     0);

    clear_buf();
    press(1, 6); press(2, 6); press(0, 6);
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("load_pulse", int'(load),     1);
    chk("load_min",   int'(min_ones), 1);
    chk("load_tens",  int'(sec_tens), 2);
    chk("load_ones",  int'(sec_ones), 0);
    tick();
    chk("load_end",     int'(load),      0);
    chk("load_cleared", int'(digit_cnt), 0);
    load_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_load", int'(load), 0);
    end
    load_req = 1'b0;

    press(4, 6); press(5, 6);
    clr = 1'b1; load_req = 1'b1; tick(); clr = 1'b0; load_req = 1'b0;
    chk("clr_load_no_load", int'(load),      0);
    chk("clr_load_cnt",     int'(digit_cnt), 0);
    tick();
    chk("clr_load_after", int'(load), 0);

    entry_en = 1'b0; enc_valid = 1'b1; enc_d = 4'd8; strobe_cnt = 0;
    repeat (8) tick();
    chk("dis_enablen", int'(enc_enablen), 1);
    chk("dis_strobe",  strobe_cnt,        0);
    chk("dis_cnt",     int'(digit_cnt),   0);
    enc_valid = 1'b0; entry_en = 1'b1;
    repeat (6) tick();

    seg_left = 0; pressing = 0; key = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      if (seg_left == 0) begin
        pressing = !pressing;
        seg_left = pressing ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 7));
        key = ($urandom_range(0, 15) == 0) ? 4'(10 + $urandom_range(0, 5))
                                           : 4'($urandom_range(0, 9));
      end
      seg_left--;
      enc_valid = pressing;
      enc_d     = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : key;
      entry_en  = ($urandom_range(0, 24) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      load_req  = ($urandom_range(0, 11) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
